// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, reset PC and instruction size.
package fetch_unit_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  // Instruction size in bytes; the PC block uses the same sequential increment.
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel plus the decode hand-off channel.
// Optional FETCH_MISALIGN_EN adds dec_misaligned.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = ADDR_W,
  parameter int unsigned DATA_SIZE    = DATA_W
);
  logic                    imem_req_valid;
  logic [ADDRESS_SIZE-1:0] imem_req_addr;
  logic                    imem_req_ready;
  logic                    imem_resp_valid;
  logic [DATA_SIZE-1:0]    imem_resp_data;
  logic                    dec_valid;
  logic [DATA_SIZE-1:0]    dec_instr;
  logic [ADDRESS_SIZE-1:0] dec_pc;
  logic                    dec_ready;
`ifdef FETCH_MISALIGN_EN
  logic                    dec_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_misaligned,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_misaligned,
    output imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
  );
`else
  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
  );
`endif
endinterface

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer: one-entry instruction/PC holding register.
// Load wins over flush/pop so a redirect can drop old contents and install a new entry together.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = ADDR_W,
  parameter int unsigned DATA_SIZE    = DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_SIZE-1:0]    load_instr,
  input  logic [ADDRESS_SIZE-1:0] load_pc,
`ifdef FETCH_MISALIGN_EN
  input  logic                    load_misaligned,
  output logic                    misaligned,
`endif
  output logic                    valid,
  output logic [DATA_SIZE-1:0]    instr,
  output logic [ADDRESS_SIZE-1:0] pc
);

  // Entry register with valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
`ifdef FETCH_MISALIGN_EN
      misaligned <= 1'b0;
`endif
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
`ifdef FETCH_MISALIGN_EN
      misaligned <= load_misaligned;
`endif
    end else if (flush || pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, one-entry buffer toward decode,
// PC_clear redirect that drains any in-flight wrong-path response.
// FETCH_MISALIGN_EN: misaligned redirects report a flagged entry and park fetch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE     = ADDR_W,
  parameter int unsigned INSTRUCTION_SIZE = INSTR_BYTES,
  parameter int unsigned DATA_SIZE        = DATA_W,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC = ADDRESS_SIZE'(RESET_PC_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] PC_next,
  input  logic                    PC_clear,
  fetch_unit_if.master            bus
);

  localparam logic [ADDRESS_SIZE-1:0] INCR        = ADDRESS_SIZE'(INSTRUCTION_SIZE);
  localparam logic [ADDRESS_SIZE-1:0] OFFSET_MASK = ADDRESS_SIZE'(INSTRUCTION_SIZE - 1);

  fetch_state_e            state, state_d;
  logic [ADDRESS_SIZE-1:0] fetch_pc, fetch_pc_d;
  logic                    req_fire, in_flight;
  logic                    buf_valid, buf_load, buf_flush, buf_pop;
  logic [DATA_SIZE-1:0]    load_instr;
  logic [ADDRESS_SIZE-1:0] load_pc;
`ifdef FETCH_MISALIGN_EN
  logic                    halted, halted_d, load_mis, redirect_misaligned;

  assign redirect_misaligned = |(PC_next & OFFSET_MASK);
  assign bus.imem_req_valid  = (state == S_REQ) && !halted;
`else
  assign bus.imem_req_valid  = (state == S_REQ);
`endif

  assign bus.imem_req_addr = fetch_pc;
  assign bus.dec_valid     = buf_valid & ~PC_clear;
  assign buf_pop           = bus.dec_valid & bus.dec_ready;
  assign req_fire          = bus.imem_req_valid & bus.imem_req_ready;
  // A response arriving in the redirect cycle itself leaves nothing outstanding to drain.
  assign in_flight = ((state == S_REQ) && req_fire) ||
                     (((state == S_WAIT) || (state == S_DRAIN)) && !bus.imem_resp_valid);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_d;
  end

  // Fetch PC and park flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
`ifdef FETCH_MISALIGN_EN
      halted   <= 1'b0;
`endif
    end else begin
      fetch_pc <= fetch_pc_d;
`ifdef FETCH_MISALIGN_EN
      halted   <= halted_d;
`endif
    end
  end

  // Next state, next PC and buffer controls; redirect overrides everything.
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    buf_load   = 1'b0;
    buf_flush  = 1'b0;
    load_instr = bus.imem_resp_data;
    load_pc    = fetch_pc;
`ifdef FETCH_MISALIGN_EN
    halted_d   = halted;
    load_mis   = 1'b0;
`endif
    if (PC_clear) begin
      buf_flush = 1'b1;
      state_d   = in_flight ? S_DRAIN : S_REQ;
`ifdef FETCH_MISALIGN_EN
      fetch_pc_d = PC_next;
      halted_d   = redirect_misaligned;
      if (redirect_misaligned) begin
        buf_load   = 1'b1;
        load_instr = '0;
        load_pc    = PC_next;
        load_mis   = 1'b1;
      end
`else
      fetch_pc_d = PC_next & ~OFFSET_MASK;
`endif
    end else begin
      case (state)
        S_REQ:   if (req_fire) state_d = S_WAIT;
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            buf_load   = 1'b1;
            fetch_pc_d = fetch_pc + INCR;
            state_d    = S_HOLD;
          end
        end
        S_HOLD:  if (buf_pop) state_d = S_REQ;
        S_DRAIN: if (bus.imem_resp_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  fetch_buffer #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .DATA_SIZE    (DATA_SIZE)
  ) u_buffer (
    .clk             (clk),
    .reset           (reset),
    .load            (buf_load),
    .pop             (buf_pop),
    .flush           (buf_flush),
    .load_instr      (load_instr),
    .load_pc         (load_pc),
`ifdef FETCH_MISALIGN_EN
    .load_misaligned (load_mis),
    .misaligned      (bus.dec_misaligned),
`endif
    .valid           (buf_valid),
    .instr           (bus.dec_instr),
    .pc              (bus.dec_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences, a redirect-target table and a randomized run
// checked against a program-order reference (expected PC stream + address-derived memory).
module tb_fetch_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc_next = '0;
  logic          pc_clear = 1'b0;

  fetch_unit_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

  fetch_unit #(
    .ADDRESS_SIZE     (AW),
    .INSTRUCTION_SIZE (4),
    .DATA_SIZE        (DW),
    .RESET_PC         (32'h0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .PC_next  (pc_next),
    .PC_clear (pc_clear),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // memory model / environment controls
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] data_q[$];
  int          ready_mode = 0;   // 0 low, 1 high, 2 random
  int          dec_mode = 0;
  int          lat_mode = 1;     // 0 random 1..4, else fixed latency
  bit          clr_req = 0;
  logic [31:0] clr_target = '0;

  // per-cycle samples
  logic        s_rv, s_rdy, s_dv, s_drdy, s_resp, s_clr;
  logic [31:0] s_ra, s_dpc, s_dinstr;
`ifdef FETCH_MISALIGN_EN
  logic        s_mis;
`endif
  bit          req_fire, dec_fire;
  int          cyc = 0;

  // reference model
  bit          model_en = 0;
  logic [31:0] exp_pc = '0;
  bit          prev_stall = 0;
  logic [31:0] prev_ra = '0;
  int          idle_cnt = 0;

  typedef struct {
    logic [31:0] target;
    logic [31:0] pc0;
    logic [31:0] pc1;
    bit          mis;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] qget(logic [31:0] q[$], int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    if (prev_stall) begin
      chk1("rand_req_held_valid", s_rv, 1'b1);
      chk("rand_req_held_addr", s_ra, prev_ra);
    end
    prev_stall = s_rv & ~s_rdy & ~s_clr;
    prev_ra    = s_ra;
    if (s_clr) begin
      chk1("rand_dec_valid_on_clear", s_dv, 1'b0);
      exp_pc = pc_next & ~32'h3;
    end else begin
      if (dec_fire) begin
        chk("rand_dec_pc", s_dpc, exp_pc);
        chk("rand_dec_instr", s_dinstr, mem_word(exp_pc));
        exp_pc   = exp_pc + 32'd4;
        idle_cnt = 0;
      end
      if (req_fire) chk("rand_req_addr", s_ra, exp_pc);
    end
    idle_cnt++;
    if (idle_cnt > 400) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rand_progress: no decode in %0d cycles, required progress", idle_cnt);
      idle_cnt = 0;
    end
  endtask

  // One clock: drive at the falling edge, sample 1ns later, then advance to the next falling edge.
  task automatic cycle();
    int lat;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    if (pend) begin
      if (pend_cnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        if (data_q.size() > 0) bus.imem_resp_data = data_q.pop_front();
        else                   bus.imem_resp_data = mem_word(pend_addr);
      end else begin
        pend_cnt--;
      end
    end
    bus.imem_req_ready = (ready_mode == 2) ? ($urandom_range(0, 2) != 0) : (ready_mode == 1);
    bus.dec_ready      = (dec_mode == 2)   ? ($urandom_range(0, 2) != 0) : (dec_mode == 1);
    pc_clear = clr_req;
    pc_next  = clr_target;
    clr_req  = 1'b0;
    #1;
    s_rv = bus.imem_req_valid;  s_ra = bus.imem_req_addr;  s_rdy = bus.imem_req_ready;
    s_dv = bus.dec_valid;       s_dpc = bus.dec_pc;        s_dinstr = bus.dec_instr;
    s_drdy = bus.dec_ready;     s_resp = bus.imem_resp_valid;  s_clr = pc_clear;
`ifdef FETCH_MISALIGN_EN
    s_mis = bus.dec_misaligned;
`endif
    req_fire = s_rv & s_rdy;
    dec_fire = s_dv & s_drdy;
    if (model_en) model_step();
    if (s_resp) pend = 1'b0;
    if (req_fire && !reset) begin
      lat       = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
      pend      = 1'b1;
      pend_cnt  = lat - 1;
      pend_addr = s_ra;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ready_mode = 0; dec_mode = 0; clr_req = 1'b0; model_en = 0;
    repeat (3) cycle();
    pend = 1'b0; data_q.delete();
    reset = 1'b0;
    exp_pc = '0; prev_stall = 0; idle_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rq[$], dpc[$], din[$];
    int          dcyc[$];
    int          resp_c, fire_c, early_req;
    logic [31:0] fire_a;
    bit          done;

    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 1'b0};
    vecs[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 1'b1};
    vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h7FFF_FFF8, 32'h7FFF_FFF8, 32'h7FFF_FFFC, 1'b0};
    vecs[4] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004, 1'b1};

    @(negedge clk);

    // Reset values and zero-wait streaming with data 0x11, 0x22.
    do_reset();
    chk1("reset_dec_valid", s_dv, 1'b0);
    chk("reset_dec_instr", s_dinstr, 32'h0);
    chk("reset_dec_pc", s_dpc, 32'h0);
    ready_mode = 1; dec_mode = 1; lat_mode = 1;
    data_q = '{32'h11, 32'h22};
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i == 0) begin
        chk1("reset_req_valid", s_rv, 1'b1);
        chk("reset_req_addr", s_ra, 32'h0);
      end
      if (req_fire) rq.push_back(s_ra);
      if (dec_fire) begin dpc.push_back(s_dpc); din.push_back(s_dinstr); dcyc.push_back(i); end
    end
    chk("stream_req_count", 32'(rq.size()), 32'd2);
    chk("stream_req0", qget(rq, 0), 32'h0);
    chk("stream_req1", qget(rq, 1), 32'h4);
    chk("stream_dec_count", 32'(dpc.size()), 32'd2);
    chk("stream_dec0_pc", qget(dpc, 0), 32'h0);
    chk("stream_dec0_instr", qget(din, 0), 32'h11);
    chk("stream_dec1_pc", qget(dpc, 1), 32'h4);
    chk("stream_dec1_instr", qget(din, 1), 32'h22);
    if (dcyc.size() == 2) begin
      chk("stream_first_dec_cycle", 32'(dcyc[0]), 32'd2);
      chk("stream_dec_spacing", 32'(dcyc[1] - dcyc[0]), 32'd3);
    end else begin
      chk("stream_dec_cycles", 32'(dcyc.size()), 32'd2);
    end

    // Request held stable while memory stalls.
    do_reset();
    ready_mode = 1; dec_mode = 1; lat_mode = 1;
    repeat (3) cycle();
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk1("stall_req_valid", s_rv, 1'b1);
      chk("stall_req_addr", s_ra, 32'h4);
    end
    ready_mode = 1;
    cycle();
    chk1("stall_req_accept", req_fire, 1'b1);
    chk("stall_req_accept_addr", s_ra, 32'h4);
    cycle();
    chk1("stall_no_duplicate", s_rv, 1'b0);
    cycle();
    chk1("stall_dec_fire", dec_fire, 1'b1);
    chk("stall_dec_pc", s_dpc, 32'h4);
    chk("stall_dec_instr", s_dinstr, mem_word(32'h4));

    // Redirect while waiting: stale response dropped, refetch after it.
    do_reset();
    ready_mode = 1; dec_mode = 1; lat_mode = 3;
    cycle();
    chk1("wait_clr_first_req", req_fire, 1'b1);
    clr_req = 1'b1; clr_target = 32'h100;
    cycle();
    chk1("wait_clr_dec_valid", s_dv, 1'b0);
    resp_c = -1; fire_c = -1; fire_a = '0; early_req = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      if (s_resp && resp_c < 0) resp_c = i;
      if (s_rv && resp_c < 0) early_req++;
      if (req_fire && fire_c < 0) begin fire_c = i; fire_a = s_ra; end
      if (dec_fire) begin
        chk("wait_clr_dec_pc", s_dpc, 32'h100);
        chk("wait_clr_dec_instr", s_dinstr, mem_word(32'h100));
        done = 1;
      end
    end
    chk1("wait_clr_decoded", done, 1'b1);
    chk("wait_clr_req_during_drain", 32'(early_req), 32'd0);
    chk("wait_clr_req_addr", fire_a, 32'h100);
    chk("wait_clr_req_after_stale", 32'(fire_c - resp_c), 32'd1);

    // Decode back-pressure holds the buffer and blocks the next request.
    do_reset();
    ready_mode = 1; dec_mode = 0; lat_mode = 1;
    repeat (2) cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk1("hold_dec_valid", s_dv, 1'b1);
      chk("hold_dec_pc", s_dpc, 32'h0);
      chk("hold_dec_instr", s_dinstr, mem_word(32'h0));
      chk1("hold_no_req", s_rv, 1'b0);
    end
    dec_mode = 1;
    cycle();
    chk1("hold_release_fire", dec_fire, 1'b1);
    cycle();
    chk1("hold_next_req_valid", s_rv, 1'b1);
    chk("hold_next_req_addr", s_ra, 32'h4);

    // Redirect in the handshake cycle voids the handshake.
    do_reset();
    ready_mode = 1; dec_mode = 1; lat_mode = 1;
    repeat (2) cycle();
    clr_req = 1'b1; clr_target = 32'h200;
    cycle();
    chk1("hs_clr_dec_valid", s_dv, 1'b0);
    cycle();
    chk1("hs_clr_req_fire", req_fire, 1'b1);
    chk("hs_clr_req_addr", s_ra, 32'h200);
    repeat (1) cycle();
    cycle();
    chk1("hs_clr_dec_fire", dec_fire, 1'b1);
    chk("hs_clr_dec_pc", s_dpc, 32'h200);
    chk("hs_clr_dec_instr", s_dinstr, mem_word(32'h200));

    // Redirect target table, including unaligned targets and PC wrap.
    do_reset();
    ready_mode = 1; dec_mode = 1; lat_mode = 1;
    for (int v = 0; v < 5; v++) begin
`ifdef FETCH_MISALIGN_EN
      if (vecs[v].mis) continue;
`endif
      clr_req = 1'b1; clr_target = vecs[v].target;
      cycle();
      rq.delete(); dpc.delete(); din.delete();
      for (int i = 0; i < 30 && dpc.size() < 2; i++) begin
        cycle();
        if (req_fire) rq.push_back(s_ra);
        if (dec_fire) begin dpc.push_back(s_dpc); din.push_back(s_dinstr); end
      end
      chk($sformatf("tbl%0d_req0", v), qget(rq, 0), vecs[v].pc0);
      chk($sformatf("tbl%0d_dec0_pc", v), qget(dpc, 0), vecs[v].pc0);
      chk($sformatf("tbl%0d_dec0_instr", v), qget(din, 0), mem_word(vecs[v].pc0));
      chk($sformatf("tbl%0d_dec1_pc", v), qget(dpc, 1), vecs[v].pc1);
      chk($sformatf("tbl%0d_dec1_instr", v), qget(din, 1), mem_word(vecs[v].pc1));
    end

`ifdef FETCH_MISALIGN_EN
    // Misaligned redirect: flagged entry, no requests until the next redirect.
    do_reset();
    ready_mode = 1; dec_mode = 0; lat_mode = 1;
    repeat (2) cycle();
    clr_req = 1'b1; clr_target = 32'h102;
    cycle();
    chk1("mis_clr_dec_valid", s_dv, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk1("mis_no_req", s_rv, 1'b0);
      chk1("mis_dec_valid", s_dv, 1'b1);
      chk("mis_dec_pc", s_dpc, 32'h102);
      chk("mis_dec_instr", s_dinstr, 32'h0);
      chk1("mis_flag", s_mis, 1'b1);
    end
    dec_mode = 1;
    cycle();
    chk1("mis_dec_fire", dec_fire, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk1("mis_idle_req", s_rv, 1'b0);
      chk1("mis_idle_dec", s_dv, 1'b0);
    end
    clr_req = 1'b1; clr_target = 32'h200;
    cycle();
    cycle();
    chk1("mis_resume_req", s_rv, 1'b1);
    chk("mis_resume_addr", s_ra, 32'h200);
    cycle();
    cycle();
    chk1("mis_resume_dec", dec_fire, 1'b1);
    chk("mis_resume_pc", s_dpc, 32'h200);
    chk1("mis_resume_flag", s_mis, 1'b0);
`endif

    // Randomized traffic against the program-order reference.
    do_reset();
    ready_mode = 2; dec_mode = 2; lat_mode = 0; model_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        clr_req = 1'b1;
        clr_target = $urandom() & 32'hFFFF_FFFC;
        if ($urandom_range(0, 3) == 0) clr_target = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
`ifndef FETCH_MISALIGN_EN
        if ($urandom_range(0, 3) == 0) clr_target = $urandom();
`endif
      end
      cycle();
    end
    model_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting upstream of decode and consuming the next-PC/flush pair produced by the branch-resolution PC block. Holds the architectural fetch PC, issues one-at-a-time word requests to instruction memory over a valid/ready channel, buffers the returned instruction, and hands it to decode with its PC. On `PC_clear` it discards wrong-path work, including an in-flight memory response, and restarts at `PC_next`.

## Interface
- `ADDRESS_SIZE`, 32, address/PC width
- `INSTRUCTION_SIZE`, 4, instruction size in bytes; sequential PC increment
- `DATA_SIZE`, 32, instruction word width
- `RESET_PC`, 0, first fetch address after reset
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `PC_next`  in  ADDRESS_SIZE  redirect target from PC block
- `PC_clear`  in  1  redirect/flush strobe from PC block
- `imem_req_valid`  out  1  request valid
- `imem_req_addr`  out  ADDRESS_SIZE  request address
- `imem_req_ready`  in  1  memory accepts request
- `imem_resp_valid`  in  1  response valid (one per accepted request, ≥1 cycle later)
- `imem_resp_data`  in  DATA_SIZE  instruction word
- `dec_valid`  out  1  instruction available to decode
- `dec_instr`  out  DATA_SIZE  instruction
- `dec_pc`  out  ADDRESS_SIZE  PC of `dec_instr` (PC_current for decode)
- `dec_ready`  in  1  decode accepts

## Operation
- States: `S_REQ` (drive request), `S_WAIT` (awaiting response), `S_HOLD` (buffer full, offering to decode), `S_DRAIN` (awaiting response to discard).
- `S_REQ`: `imem_req_valid`=1, addr=`fetch_pc`; on valid&ready → `S_WAIT`.
- `S_WAIT`: on `imem_resp_valid` capture data and `fetch_pc` into buffer, `fetch_pc += INSTRUCTION_SIZE` → `S_HOLD`.
- `S_HOLD`: `dec_valid`=1; on `dec_valid & dec_ready` → `S_REQ`.
- `PC_clear` (highest priority, any state): `fetch_pc` ← `PC_next`, buffer invalidated; from `S_WAIT`, or `S_REQ` with request accepted that cycle → `S_DRAIN`; otherwise → `S_REQ`.
- `S_DRAIN`: request not driven; on `imem_resp_valid` drop data → `S_REQ`. A further `PC_clear` in `S_DRAIN` updates `fetch_pc` and stays in `S_DRAIN`.
- `dec_valid` = buffer valid & !`PC_clear` (combinational gate); a handshake in a `PC_clear` cycle is void.
- PC arithmetic modulo 2^ADDRESS_SIZE; wrap from max to 0 is silent.
- `imem_req_addr` must stay stable while valid & !ready; `PC_clear` is the only event that changes it mid-request.

## Timing
- Reset: state `S_REQ`, `fetch_pc`=`RESET_PC`, buffer invalid; `dec_valid`=0, `dec_instr`=0, `dec_pc`=0; `imem_req_valid`=1 from the first cycle with `reset` low.
- Reset mid-transfer: outstanding response after reset is not tracked; memory is reset concurrently.
- Response captured on the edge it is valid; `dec_valid` rises the following cycle.
- Next request issued the cycle after the decode handshake.
- Zero-wait memory (ready=1, 1-cycle response): one instruction per 3 cycles.
- `PC_clear` to first redirect request: next cycle if nothing in flight; otherwise the cycle after the stale response.

## Configuration
- `FETCH_MISALIGN_EN` defined: extra output `dec_misaligned` (1 bit, reset 0). Redirect to an address with nonzero low log2(INSTRUCTION_SIZE) bits issues no request; the buffer is loaded with `dec_instr`=0, `dec_pc`=target, `dec_misaligned`=1, and after the handshake fetch idles (no requests) until the next `PC_clear`.
- Undefined: low bits of `PC_next` forced to zero on redirect; no extra port.

## Structure
- Shared package: state enum (`S_REQ`, `S_WAIT`, `S_HOLD`, `S_DRAIN`), `RESET_PC` default, instruction-size constant shared with the PC block.
- One sub-module: `fetch_buffer` (one-entry instruction/PC register with valid, load, pop, flush).

## Test plan
- Reset release, memory ready=1, 1-cycle latency, data 0x11,0x22 -> requests at 0x0, 0x4; decode sees (0x0,0x11), (0x4,0x22), 3 cycles apart.
- `imem_req_ready` low 4 cycles -> `imem_req_addr` held at 0x4 throughout; no duplicate request.
- `PC_clear` with `PC_next`=0x100 while in `S_WAIT` -> stale response discarded; next request 0x100; decode never sees stale data.
- `dec_ready` low 5 cycles in `S_HOLD` -> no new request; `dec_instr`/`dec_pc` stable.
- `PC_clear` same cycle as decode handshake -> `dec_valid` reads 0; refetch from `PC_next`.
- With `FETCH_MISALIGN_EN`, redirect to 0x102 -> no request; `dec_valid`=1, `dec_pc`=0x102, `dec_misaligned`=1; requests resume only after next `PC_clear`.
